gpio_input_conditioner: RTL and testbench

Input-conditioning stage between the GPIO pads and the `gpio_i` input of the GPIO APB peripheral. Each pin goes through a two-flop synchroniser and a per-bit debounce filter, and the filtered value drives the GPIO block. Rising and falling edges of the filtered value set sticky interrupt flags. The debounce threshold, edge enables and flags sit in a small APB register file on the same 4-bit-address, 8-bit-data bus as the GPIO block.

---
 rtl/gpio_cond_pkg.sv | 12 +
 rtl/gpio_debounce_bit.sv | 35 +++
 rtl/gpio_input_conditioner.sv | 67 ++++++
 tb/tb_gpio_input_conditioner.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/gpio_cond_pkg.sv
// gpio_cond_pkg: register map and reset constants for the GPIO input conditioner
package gpio_cond_pkg;
  localparam logic [3:0] DB_THRESH_ADDR  = 4'h0;
  localparam logic [3:0] RISE_EN_ADDR    = 4'h1;
  localparam logic [3:0] FALL_EN_ADDR    = 4'h2;
  localparam logic [3:0] INT_STATUS_ADDR = 4'h3;
  localparam logic [3:0] CLEAN_ADDR      = 4'h4;
  localparam logic [3:0] RAW_SYNC_ADDR   = 4'h5;
  localparam logic [7:0] DB_THRESH_RST   = 8'h03;
  localparam logic [7:0] EN_RST          = 8'h00;
  localparam logic [7:0] STATUS_RST      = 8'h00;
endpackage

// File: rtl/gpio_debounce_bit.sv
// gpio_debounce_bit: two-flop synchroniser plus debounce filter with edge pulses for one pin
module gpio_debounce_bit #(
  parameter int DB_W = 8
) (
  input  logic            pclk,
  input  logic            preset_n,
  input  logic            pad,
  input  logic [DB_W-1:0] thresh,
  output logic            sync,
  output logic            clean,
  output logic            rise,
  output logic            fall
);
  logic            s1;
  logic [DB_W-1:0] cnt;
  logic            accept;
  // >= rather than == so a lowered threshold applies at once and cnt never wraps
  always_comb begin
    accept = (sync != clean) && (cnt >= thresh);
    rise   = accept & sync;
    fall   = accept & ~sync;
  end
  always_ff @(posedge pclk or negedge preset_n)
    if (!preset_n) begin
      s1    <= 1'b0;
      sync  <= 1'b0;
      clean <= 1'b0;
      cnt   <= '0;
    end else begin
      s1    <= pad;
      sync  <= s1;
      clean <= accept ? sync : clean;
      cnt   <= (sync == clean || accept) ? '0 : cnt + DB_W'(1);
    end
endmodule

// File: rtl/gpio_input_conditioner.sv
// gpio_input_conditioner: per-pin sync/debounce with sticky edge interrupts behind an APB register file
module gpio_input_conditioner
  import gpio_cond_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DB_W  = 8
) (
  input  logic             pclk,
  input  logic             preset_n,
  input  logic             psel_i,
  input  logic             penable_i,
  input  logic [3:0]       paddr_i,
  input  logic             pwrite_i,
  input  logic [7:0]       pwdata_i,
  output logic [7:0]       prdata_o,
  output logic             pready_o,
  input  logic [WIDTH-1:0] pad_i,
  output logic [WIDTH-1:0] gpio_clean_o,
  output logic             irq_o
);
  logic [DB_W-1:0]  db_thresh;
  logic [WIDTH-1:0] rise_en, fall_en, int_status;
  logic [WIDTH-1:0] raw_sync, rise, fall, w1c;
  logic [7:0]       rd;
  logic             wr;
  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_bit
      gpio_debounce_bit #(.DB_W(DB_W)) u_db (
        .pclk    (pclk),
        .preset_n(preset_n),
        .pad     (pad_i[i]),
        .thresh  (db_thresh),
        .sync    (raw_sync[i]),
        .clean   (gpio_clean_o[i]),
        .rise    (rise[i]),
        .fall    (fall[i])
      );
    end
  endgenerate
  always_comb begin
    wr       = psel_i & penable_i & pwrite_i;
    w1c      = (wr && paddr_i == INT_STATUS_ADDR) ? pwdata_i[WIDTH-1:0] : '0;
    rd       = (paddr_i == DB_THRESH_ADDR)  ? 8'(db_thresh)    :
               (paddr_i == RISE_EN_ADDR)    ? 8'(rise_en)      :
               (paddr_i == FALL_EN_ADDR)    ? 8'(fall_en)      :
               (paddr_i == INT_STATUS_ADDR) ? 8'(int_status)   :
               (paddr_i == CLEAN_ADDR)      ? 8'(gpio_clean_o) :
               (paddr_i == RAW_SYNC_ADDR)   ? 8'(raw_sync)     : 8'h00;
    prdata_o = (psel_i & ~pwrite_i) ? rd : 8'h00;
    pready_o = 1'b1;
    irq_o    = |int_status;
  end
  // a new edge sets its flag even when the same bit is being W1C-cleared
  always_ff @(posedge pclk or negedge preset_n)
    if (!preset_n) begin
      db_thresh  <= DB_THRESH_RST[DB_W-1:0];
      rise_en    <= EN_RST[WIDTH-1:0];
      fall_en    <= EN_RST[WIDTH-1:0];
      int_status <= STATUS_RST[WIDTH-1:0];
    end else begin
      db_thresh  <= (wr && paddr_i == DB_THRESH_ADDR) ? pwdata_i[DB_W-1:0] : db_thresh;
      rise_en    <= (wr && paddr_i == RISE_EN_ADDR) ? pwdata_i[WIDTH-1:0] : rise_en;
      fall_en    <= (wr && paddr_i == FALL_EN_ADDR) ? pwdata_i[WIDTH-1:0] : fall_en;
      int_status <= (int_status & ~w1c) | (rise & rise_en) | (fall & fall_en);
    end
endmodule

// File: tb/tb_gpio_input_conditioner.sv
// tb_gpio_input_conditioner: directed-vector bench for the GPIO input conditioner
module tb_gpio_input_conditioner;
  import gpio_cond_pkg::*;
  logic       pclk = 1'b0;
  logic       preset_n;
  logic       psel_i, penable_i, pwrite_i;
  logic [3:0] paddr_i;
  logic [7:0] pwdata_i, prdata_o, pad_i, gpio_clean_o;
  logic       pready_o, irq_o;
  logic [7:0] rd;
  int tests = 0;
  int fails = 0;

  gpio_input_conditioner #(.WIDTH(8), .DB_W(8)) dut (
    .pclk        (pclk),
    .preset_n    (preset_n),
    .psel_i      (psel_i),
    .penable_i   (penable_i),
    .paddr_i     (paddr_i),
    .pwrite_i    (pwrite_i),
    .pwdata_i    (pwdata_i),
    .prdata_o    (prdata_o),
    .pready_o    (pready_o),
    .pad_i       (pad_i),
    .gpio_clean_o(gpio_clean_o),
    .irq_o       (irq_o)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // setup at one negedge, enable at the next; access edge is the following posedge
  task automatic apb_write(input logic [3:0] a, input logic [7:0] d);
    @(negedge pclk);
    psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b1; paddr_i = a; pwdata_i = d;
    @(negedge pclk);
    penable_i = 1'b1;
    @(negedge pclk);
    psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
  endtask

  task automatic apb_read(input logic [3:0] a, output logic [7:0] d);
    @(negedge pclk);
    psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b0; paddr_i = a;
    #1 d = prdata_o;
    psel_i = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_rst [6];
    exp_rst = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    preset_n = 1'b0; psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
    paddr_i = 4'h0; pwdata_i = 8'h00; pad_i = 8'h00;
    repeat (3) @(negedge pclk);
    preset_n = 1'b1;
    // reset state
    check("rst_clean", gpio_clean_o, 8'h00);
    check("rst_irq", irq_o, 1'b0);
    check("rst_pready", pready_o, 1'b1);
    check("rst_prdata_idle", prdata_o, 8'h00);
    for (int a = 0; a < 6; a++) begin
      apb_read(4'(a), rd);
      check($sformatf("rst_reg%0d", a), rd, exp_rst[a]);
    end
    // rising edge with interrupt, threshold 3 -> clean at sixth edge
    apb_write(RISE_EN_ADDR, 8'h01);
    pad_i = 8'h01;
    repeat (5) @(negedge pclk);
    check("rise_clean_e5", gpio_clean_o, 8'h00);
    check("rise_irq_e5", irq_o, 1'b0);
    @(negedge pclk);
    check("rise_clean_e6", gpio_clean_o, 8'h01);
    check("rise_irq_e6", irq_o, 1'b1);
    apb_read(INT_STATUS_ADDR, rd);
    check("rise_status", rd, 8'h01);
    apb_write(INT_STATUS_ADDR, 8'h01);
    check("w1c_irq", irq_o, 1'b0);
    apb_read(INT_STATUS_ADDR, rd);
    check("w1c_status", rd, 8'h00);
    // glitch rejection on bit 2: 3-high/1-low pulses never accepted
    apb_write(RISE_EN_ADDR, 8'h05);
    for (int p = 0; p < 4; p++) begin
      pad_i = 8'h05;
      repeat (3) @(negedge pclk);
      pad_i = 8'h01;
      @(negedge pclk);
    end
    repeat (6) @(negedge pclk);
    check("glitch_clean", gpio_clean_o, 8'h01);
    check("glitch_irq", irq_o, 1'b0);
    apb_read(INT_STATUS_ADDR, rd);
    check("glitch_status", rd, 8'h00);
    // 4-cycle pulse is accepted at the sixth edge
    @(negedge pclk);
    pad_i = 8'h05;
    repeat (4) @(negedge pclk);
    pad_i = 8'h01;
    repeat (2) @(negedge pclk);
    check("pulse4_clean", gpio_clean_o, 8'h05);
    check("pulse4_irq", irq_o, 1'b1);
    repeat (10) @(negedge pclk);
    check("pulse4_fall", gpio_clean_o, 8'h01);
    apb_read(INT_STATUS_ADDR, rd);
    check("pulse4_status", rd, 8'h04);
    apb_write(INT_STATUS_ADDR, 8'h04);
    check("pulse4_w1c_irq", irq_o, 1'b0);
    // set beats clear on bit 7
    apb_write(FALL_EN_ADDR, 8'h80);
    pad_i = 8'h81;
    repeat (10) @(negedge pclk);
    check("b7_high", gpio_clean_o, 8'h81);
    check("b7_no_flag", irq_o, 1'b0);
    pad_i = 8'h01;
    repeat (3) @(negedge pclk);
    apb_write(INT_STATUS_ADDR, 8'h80);
    check("b7_fall", gpio_clean_o, 8'h01);
    apb_read(INT_STATUS_ADDR, rd);
    check("set_beats_clear", rd, 8'h80);
    check("set_beats_clear_irq", irq_o, 1'b1);
    // threshold 0 -> three-cycle latency
    apb_write(DB_THRESH_ADDR, 8'h00);
    pad_i = 8'h03;
    repeat (2) @(negedge pclk);
    check("th0_e2", gpio_clean_o, 8'h01);
    @(negedge pclk);
    check("th0_e3", gpio_clean_o, 8'h03);
    // threshold raised to 0xFF mid-count: accepted after 256 disagreeing cycles
    apb_write(DB_THRESH_ADDR, 8'h03);
    pad_i = 8'h01;
    apb_write(DB_THRESH_ADDR, 8'hFF);
    repeat (254) @(negedge pclk);
    check("thff_e257", gpio_clean_o, 8'h03);
    @(negedge pclk);
    check("thff_e258", gpio_clean_o, 8'h01);
    apb_read(DB_THRESH_ADDR, rd);
    check("thff_read", rd, 8'hFF);
    apb_write(DB_THRESH_ADDR, 8'h03);
    // unmapped address
    apb_write(4'hF, 8'hAA);
    apb_read(4'hF, rd);
    check("unmapped_read", rd, 8'h00);
    apb_read(DB_THRESH_ADDR, rd);
    check("unmapped_thresh", rd, 8'h03);
    apb_read(FALL_EN_ADDR, rd);
    check("unmapped_fall_en", rd, 8'h80);
    apb_read(CLEAN_ADDR, rd);
    check("clean_read", rd, 8'h01);
    apb_read(RAW_SYNC_ADDR, rd);
    check("raw_sync_read", rd, 8'h01);
    // reset mid-count
    apb_write(RISE_EN_ADDR, 8'h10);
    pad_i = 8'h11;
    repeat (3) @(negedge pclk);
    check("pre_rst_irq", irq_o, 1'b1);
    #2 preset_n = 1'b0;
    #1;
    check("mid_rst_clean", gpio_clean_o, 8'h00);
    check("mid_rst_irq", irq_o, 1'b0);
    apb_read(INT_STATUS_ADDR, rd);
    check("mid_rst_status", rd, 8'h00);
    apb_read(RISE_EN_ADDR, rd);
    check("mid_rst_rise_en", rd, 8'h00);
    @(negedge pclk);
    preset_n = 1'b1;
    repeat (5) @(negedge pclk);
    check("post_rst_e5", gpio_clean_o, 8'h00);
    @(negedge pclk);
    check("post_rst_e6", gpio_clean_o, 8'h11);
    check("post_rst_irq", irq_o, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
